spectrum_framer: RTL and testbench

Upstream feeder for the formant tracker. Accepts a streaming complex FFT frame (one bin per valid beat) and computes the power |X|^2 of each bin. It keeps the lowest I bins in an internal buffer. Once the frame ends, it replays those I power values as one gap-free burst on fft_valid/fft_data, which is the contiguous 160-cycle burst the formant stage requires. It then enforces a hold-off so the downstream DP can finish before the next burst; frames arriving during EMIT/HOLDOFF are dropped whole.

---
 rtl/spectrum_framer_if.sv | 24 ++
 rtl/spectrum_framer.sv | 137 +++++++++++++
 tb/tb_spectrum_framer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spectrum_framer_if.sv
// Bin stream in, power burst out; the framer is the slave and the feeder/bench is the master.
interface spectrum_framer_if #(
    parameter int IN_WIDTH  = 16,
    parameter int BIT_WIDTH = 32
);
    logic                        bin_valid;
    logic                        bin_last;
    logic signed [IN_WIDTH-1:0]  bin_re;
    logic signed [IN_WIDTH-1:0]  bin_im;
    logic                        fft_valid;
    logic        [BIT_WIDTH-1:0] fft_data;
    logic                        frame_dropped;
    logic                        busy;

    modport master (
        output bin_valid, bin_last, bin_re, bin_im,
        input  fft_valid, fft_data, frame_dropped, busy
    );

    modport slave (
        input  bin_valid, bin_last, bin_re, bin_im,
        output fft_valid, fft_data, frame_dropped, busy
    );
endinterface

// File: rtl/spectrum_framer.sv
// Per-bin power capture of the lowest I bins, replayed as one gap-free burst; fft_valid rises 3 edges after bin_last.
// No backpressure: bins are always accepted, and frames that cannot be captured are dropped whole.
module spectrum_framer #(
    parameter int IN_WIDTH  = 16,
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int SHIFT     = 0,
    parameter int HOLDOFF   = 1000000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    spectrum_framer_if.slave bus
);
    localparam int CW       = $clog2(I + 1);
    localparam int IW       = (I > 1) ? $clog2(I) : 1;
    localparam int HW       = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int HOLD_END = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam int PW       = 2 * IN_WIDTH;
    localparam int SW       = PW + 1;
    localparam int XW       = (BIT_WIDTH >= SW) ? BIT_WIDTH + 1 : SW;

    typedef enum logic [1:0] {S_CAPTURE, S_DRAIN, S_EMIT, S_HOLDOFF} state_t;

    state_t                 state, state_nxt;
    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   aligned, aligned_nxt;
    logic                   drain_cnt;
    logic [IW-1:0]          rd_idx;
    logic [HW-1:0]          hcnt;
    logic signed [PW-1:0]   p_re, p_im;
    logic                   wr_en, wr_en1;
    logic [IW-1:0]          wr_idx1;
    logic                   drop, last_seen;
    logic [SW-1:0]          sum;
    logic [XW-1:0]          ext;
    logic [BIT_WIDTH-1:0]   pow_sat;
    logic [BIT_WIDTH-1:0]   buffer [I];

    // Assert asynchronously, release two clocks later.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign sum     = {1'b0, p_re} + {1'b0, p_im};
    assign ext     = XW'(sum >> SHIFT);
    assign pow_sat = (|ext[XW-1:BIT_WIDTH]) ? '1 : ext[BIT_WIDTH-1:0];
    assign bus.busy = (state != S_CAPTURE);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= S_CAPTURE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        aligned_nxt = aligned;
        drop        = 1'b0;
        last_seen   = bus.bin_valid && bus.bin_last;
        wr_en       = bus.bin_valid && (state == S_CAPTURE) && aligned && (cnt < CW'(I));
        if (bus.bin_valid) begin
            if (bus.bin_last)       cnt_nxt = '0;
            else if (cnt < CW'(I))  cnt_nxt = cnt + 1'b1;
        end
        case (state)
            S_CAPTURE: begin
                if (last_seen) begin
                    if (aligned && (cnt >= CW'(I - 1))) begin
                        state_nxt = S_DRAIN;
                    end else begin
                        drop        = 1'b1;
                        aligned_nxt = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                drop = last_seen;
                if (drain_cnt) state_nxt = S_EMIT;
            end
            S_EMIT: begin
                drop = last_seen;
                if (rd_idx == IW'(I - 1)) state_nxt = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                drop = last_seen;
                // A frame still arriving at the return to capture began unseen, so it must not be written.
                if (hcnt == HW'(HOLD_END)) begin
                    state_nxt   = S_CAPTURE;
                    aligned_nxt = (cnt_nxt == '0);
                end
            end
            default: state_nxt = S_CAPTURE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt               <= '0;
            aligned           <= 1'b1;
            drain_cnt         <= 1'b0;
            rd_idx            <= '0;
            hcnt              <= '0;
            p_re              <= '0;
            p_im              <= '0;
            wr_en1            <= 1'b0;
            wr_idx1           <= '0;
            bus.fft_valid     <= 1'b0;
            bus.fft_data      <= '0;
            bus.frame_dropped <= 1'b0;
        end else begin
            cnt               <= cnt_nxt;
            aligned           <= aligned_nxt;
            drain_cnt         <= (state == S_DRAIN) && !drain_cnt;
            rd_idx            <= (state == S_EMIT && state_nxt == S_EMIT) ? rd_idx + 1'b1 : '0;
            hcnt              <= (state == S_HOLDOFF) ? hcnt + 1'b1 : '0;
            p_re              <= bus.bin_re * bus.bin_re;
            p_im              <= bus.bin_im * bus.bin_im;
            wr_en1            <= wr_en;
            wr_idx1           <= cnt[IW-1:0];
            bus.frame_dropped <= drop;
            if (state == S_EMIT) begin
                bus.fft_valid <= 1'b1;
                bus.fft_data  <= buffer[rd_idx];
            end else begin
                bus.fft_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en1) buffer[wr_idx1] <= pow_sat;
    end
endmodule

// File: tb/tb_spectrum_framer.sv
// Directed bench: three framer instances (32-bit, 24-bit unshifted, 24-bit shifted) share one bin stream.
module tb_spectrum_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               bv, bl;
    logic signed [15:0] re, im;
    int                 cyc = 0;
    always @(posedge clk) cyc++;

    spectrum_framer_if #(.IN_WIDTH(16), .BIT_WIDTH(32)) if0 ();
    spectrum_framer_if #(.IN_WIDTH(16), .BIT_WIDTH(24)) if1 ();
    spectrum_framer_if #(.IN_WIDTH(16), .BIT_WIDTH(24)) if2 ();

    assign if0.bin_valid = bv; assign if0.bin_last = bl; assign if0.bin_re = re; assign if0.bin_im = im;
    assign if1.bin_valid = bv; assign if1.bin_last = bl; assign if1.bin_re = re; assign if1.bin_im = im;
    assign if2.bin_valid = bv; assign if2.bin_last = bl; assign if2.bin_re = re; assign if2.bin_im = im;

    spectrum_framer #(.IN_WIDTH(16), .BIT_WIDTH(32), .I(160), .SHIFT(0), .HOLDOFF(10))
        dut0 (.clk_in(clk), .rst_in(rst), .bus(if0));
    spectrum_framer #(.IN_WIDTH(16), .BIT_WIDTH(24), .I(160), .SHIFT(0), .HOLDOFF(10))
        dut1 (.clk_in(clk), .rst_in(rst), .bus(if1));
    spectrum_framer #(.IN_WIDTH(16), .BIT_WIDTH(24), .I(160), .SHIFT(8), .HOLDOFF(10))
        dut2 (.clk_in(clk), .rst_in(rst), .bus(if2));

    logic        vld_w [3];
    logic [31:0] dat_w [3];
    logic        drp_w [3];
    assign vld_w[0] = if0.fft_valid; assign dat_w[0] = if0.fft_data;          assign drp_w[0] = if0.frame_dropped;
    assign vld_w[1] = if1.fft_valid; assign dat_w[1] = {8'h00, if1.fft_data}; assign drp_w[1] = if1.frame_dropped;
    assign vld_w[2] = if2.fft_valid; assign dat_w[2] = {8'h00, if2.fft_data}; assign drp_w[2] = if2.frame_dropped;

    // Burst recorder: one captured burst per instance plus rise time, run length and drop pulse count.
    logic        pv       [3] = '{1'b0, 1'b0, 1'b0};
    int          bursts   [3] = '{0, 0, 0};
    int          ncap     [3] = '{0, 0, 0};
    int          last_run [3] = '{0, 0, 0};
    int          rise     [3] = '{0, 0, 0};
    int          drops    [3] = '{0, 0, 0};
    logic [31:0] cap      [3][160];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (vld_w[d]) begin
                if (!pv[d]) begin
                    bursts[d]++;
                    rise[d] = cyc;
                    ncap[d] = 0;
                end
                if (ncap[d] < 160) cap[d][ncap[d]] = dat_w[d];
                ncap[d]++;
            end else if (pv[d]) begin
                last_run[d] = ncap[d];
            end
            pv[d] = vld_w[d];
            if (drp_w[d]) drops[d]++;
        end
    end

    int total = 0;
    int bad   = 0;
    int last_edge = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] model(input int mode, input int k, input int d);
        case (mode)
            0:       return 32'(k * k);
            2:       return 32'(5 * k * k);
            default: return (d == 0) ? 32'h8000_0000 : ((d == 1) ? 32'h00FF_FFFF : 32'h0080_0000);
        endcase
    endfunction

    task automatic send_frame(input int n, input int mode, input int gapmax);
        for (int k = 0; k < n; k++) begin
            int g;
            g  = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            bv = 1'b0;
            bl = 1'b0;
            tick(g);
            bv = 1'b1;
            bl = (k == n - 1);
            case (mode)
                0:       begin re = 16'(k);  im = 16'sd0;     end
                1:       begin re = -16'sd32768; im = -16'sd32768; end
                default: begin re = 16'(k);  im = 16'(2 * k); end
            endcase
            tick(1);
            if (k == n - 1) last_edge = cyc;
        end
        bv = 1'b0;
        bl = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (if0.busy && w < 3000) begin
            tick(1);
            w++;
        end
        chk("idle_timeout", longint'(if0.busy), 0);
    endtask

    task automatic check_burst(input string nm, input int mode, input int d);
        int badn;
        badn = 0;
        chk({nm, "_runlen"}, last_run[d], 160);
        for (int k = 0; k < 160; k++)
            if (cap[d][k] !== model(mode, k, d)) badn++;
        chk({nm, "_bins_wrong"}, badn, 0);
    endtask

    typedef struct {
        int n;
        int mode;
        int gap;
        int exp_bursts;
        int exp_drops;
    } vec_t;

    vec_t tbl [7];
    int   b0, dr0, le, w;

    initial begin
        tbl[0] = '{512, 0, 0, 1, 0};   // k^2 ramp
        tbl[1] = '{512, 1, 0, 1, 0};   // full-scale saturation / shift
        tbl[2] = '{100, 0, 0, 0, 1};   // short frame dropped
        tbl[3] = '{512, 0, 0, 1, 0};   // recovers from bin 0
        tbl[4] = '{512, 2, 3, 1, 0};   // gappy input, 5k^2
        tbl[5] = '{160, 2, 0, 1, 0};   // exactly I bins
        tbl[6] = '{159, 0, 0, 0, 1};   // one bin short

        rst = 1'b0; bv = 1'b0; bl = 1'b0; re = '0; im = '0;
        tick(3);
        chk("rst_fft_valid", longint'(if0.fft_valid), 0);
        chk("rst_fft_data", longint'(if0.fft_data), 0);
        chk("rst_frame_dropped", longint'(if0.frame_dropped), 0);
        chk("rst_busy", longint'(if0.busy), 0);
        rst = 1'b1;
        tick(5);

        for (int v = 0; v < 7; v++) begin
            b0  = bursts[0];
            dr0 = drops[0];
            send_frame(tbl[v].n, tbl[v].mode, tbl[v].gap);
            le = last_edge;
            tick(4);
            wait_idle();
            tick(3);
            chk($sformatf("v%0d_bursts", v), bursts[0] - b0, tbl[v].exp_bursts);
            chk($sformatf("v%0d_drops", v), drops[0] - dr0, tbl[v].exp_drops);
            if (tbl[v].exp_bursts == 1) begin
                chk($sformatf("v%0d_latency", v), rise[0] - le, 3);
                chk($sformatf("v%0d_hold_data", v), longint'(if0.fft_data), longint'(model(tbl[v].mode, 159, 0)));
                check_burst($sformatf("v%0d_d0", v), tbl[v].mode, 0);
                if (tbl[v].mode == 1) begin
                    check_burst($sformatf("v%0d_d1", v), 1, 1);
                    check_burst($sformatf("v%0d_d2", v), 1, 2);
                end
            end
        end

        // Second frame starts mid-EMIT and straddles HOLDOFF: dropped whole, buffer untouched.
        b0  = bursts[0];
        dr0 = drops[0];
        send_frame(512, 0, 0);
        le = last_edge;
        w  = 0;
        while (!(bursts[0] == b0 + 1 && ncap[0] >= 5) && w < 200) begin
            tick(1);
            w++;
        end
        chk("ovl_emit_seen", longint'(bursts[0] - b0), 1);
        send_frame(512, 1, 0);
        tick(4);
        wait_idle();
        tick(3);
        chk("ovl_bursts", bursts[0] - b0, 1);
        chk("ovl_drops", drops[0] - dr0, 1);
        chk("ovl_latency", rise[0] - le, 3);
        check_burst("ovl_first", 0, 0);
        b0  = bursts[0];
        dr0 = drops[0];
        send_frame(512, 2, 0);
        tick(4);
        wait_idle();
        tick(3);
        chk("ovl_third_bursts", bursts[0] - b0, 1);
        chk("ovl_third_drops", drops[0] - dr0, 0);
        check_burst("ovl_third", 2, 0);

        // Reset asserted during the 50th output beat.
        send_frame(512, 0, 0);
        le = last_edge;
        w  = 0;
        while (cyc < le + 52 && w < 2000) begin
            tick(1);
            w++;
        end
        chk("mid_pre_valid", longint'(if0.fft_valid), 1);
        chk("mid_pre_data", longint'(if0.fft_data), 2401);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_valid", longint'(if0.fft_valid), 0);
        chk("mid_rst_data", longint'(if0.fft_data), 0);
        chk("mid_rst_busy", longint'(if0.busy), 0);
        chk("mid_rst_valid_d1", longint'(if1.fft_valid), 0);
        tick(3);
        rst = 1'b1;
        tick(6);
        b0  = bursts[0];
        dr0 = drops[0];
        send_frame(512, 2, 0);
        le = last_edge;
        tick(4);
        wait_idle();
        tick(3);
        chk("post_rst_bursts", bursts[0] - b0, 1);
        chk("post_rst_drops", drops[0] - dr0, 0);
        chk("post_rst_latency", rise[0] - le, 3);
        check_burst("post_rst", 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
